// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: one result bit per cycle, 2*WIDTH-bit result split into hi/lo.
// Define MULDIV_SIGNED_EN for two's-complement (mult/div) operands; otherwise operands are unsigned.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [2:0]         state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;

`ifdef MULDIV_SIGNED_EN
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] prod_fix;

  // Magnitude of the most negative value is still correct when read as unsigned.
  assign mag_a = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b = b_q[WIDTH-1] ? -b_q : b_q;

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == S_PREP) begin
      neg_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      neg_r_d = a_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  assign prod_fix = neg_q_q ? -acc_q : acc_q;

  always_comb begin
    if (op_q) begin
      fix_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end
`else
  assign mag_a  = a_q;
  assign mag_b  = b_q;
  assign fix_hi = acc_q[2*WIDTH-1:WIDTH];
  assign fix_lo = acc_q[WIDTH-1:0];
`endif

  // Mult: acc = {partial product, remaining multiplier bits}; carry lands in the shifted-in MSB.
  assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? dvs_q : {WIDTH{1'b0}})};
  // Div: acc = {remainder, dividend/quotient}; trial[WIDTH] set means the subtraction went negative.
  assign trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, dvs_q};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_PREP;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      S_PREP: begin
        if (op_q && (b_q == '0)) begin
          state_d = S_DONE;
          dz_d    = 1'b1;
        end else begin
          dvs_d   = op_q ? mag_b : mag_a;
          acc_d   = {{WIDTH{1'b0}}, (op_q ? mag_a : mag_b)};
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (op_q) begin
          acc_d = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PREP) || (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
